lc2k_decode_stage: RTL

Parametrised LC2K decode stage: register file, instruction field decode, load-use hazard stall, and an ID/EX pipeline register with a valid/ready handshake on both sides. It sits between fetch (IF/ID) and execute. Write-back results arrive on a dedicated write port. Execute receives operand values, sign-extended offset, register indices and PC+1.

---
 rtl/lc2k_pkg.sv | 57 +++++
 rtl/lc2k_decode_stage_if.sv | 38 +++
 rtl/lc2k_regfile_p.sv | 50 +++++
 rtl/lc2k_decode_stage.sv | 110 +++++++++++
 4 files changed

// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: opcodes, instruction field positions, pipeline
// field structs and the source-register usage table.
package lc2k_pkg;

    localparam int LC2K_NUM_REGS = 8;
    localparam int REG_IDX_W     = 3;
    localparam int INSTR_W       = 32;

    localparam int OPCODE_MSB = 24;
    localparam int OPCODE_LSB = 22;
    localparam int REG_A_MSB  = 21;
    localparam int REG_A_LSB  = 19;
    localparam int REG_B_MSB  = 18;
    localparam int REG_B_LSB  = 16;
    localparam int DEST_MSB   = 2;
    localparam int DEST_LSB   = 0;
    localparam int OFFSET_MSB = 15;
    localparam int OFFSET_LSB = 0;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_NOR  = 3'd1,
        OP_LW   = 3'd2,
        OP_SW   = 3'd3,
        OP_BEQ  = 3'd4,
        OP_JALR = 3'd5,
        OP_HALT = 3'd6,
        OP_NOOP = 3'd7
    } opcode_e;

    // IF/ID view of one instruction after field extraction.
    typedef struct packed {
        opcode_e                opcode;
        logic [REG_IDX_W-1:0]   reg_a;
        logic [REG_IDX_W-1:0]   reg_b;
        logic [REG_IDX_W-1:0]   dest;
        logic [15:0]            offset;
    } if_id_fields_t;

    // Width-independent part of the ID/EX register; data fields are added
    // by the stage at its own DATA_W/PC_W.
    typedef struct packed {
        opcode_e                opcode;
        logic [REG_IDX_W-1:0]   reg_a;
        logic [REG_IDX_W-1:0]   reg_b;
        logic [REG_IDX_W-1:0]   dest;
    } id_ex_ctrl_t;

    function automatic logic uses_reg_a(opcode_e op);
        return op inside {OP_ADD, OP_NOR, OP_LW, OP_SW, OP_BEQ, OP_JALR};
    endfunction

    function automatic logic uses_reg_b(opcode_e op);
        return op inside {OP_ADD, OP_NOR, OP_SW, OP_BEQ};
    endfunction

endpackage

// File: rtl/lc2k_decode_stage_if.sv
// Decode-stage bus: IF/ID handshake, write-back port, flush and ID/EX outputs.
interface lc2k_decode_stage_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc_plus_one;
    logic              wb_en;
    logic [2:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_opcode;
    logic [2:0]        out_reg_a;
    logic [2:0]        out_reg_b;
    logic [2:0]        out_dest;
    logic [DATA_W-1:0] out_val_a;
    logic [DATA_W-1:0] out_val_b;
    logic [DATA_W-1:0] out_offset;
    logic [PC_W-1:0]   out_pc_plus_one;

    modport master (
        output in_valid, in_instr, in_pc_plus_one, wb_en, wb_reg, wb_data,
               flush, out_ready,
        input  in_ready, out_valid, out_opcode, out_reg_a, out_reg_b, out_dest,
               out_val_a, out_val_b, out_offset, out_pc_plus_one
    );

    modport slave (
        input  in_valid, in_instr, in_pc_plus_one, wb_en, wb_reg, wb_data,
               flush, out_ready,
        output in_ready, out_valid, out_opcode, out_reg_a, out_reg_b, out_dest,
               out_val_a, out_val_b, out_offset, out_pc_plus_one
    );
endinterface

// File: rtl/lc2k_regfile_p.sv
// LC2K register file, two combinational read ports, one write port, r0 hard zero.
// LC2K_DECODE_WB_BYPASS_EN makes reads see a same-cycle write (write-through).
module lc2k_regfile_p
    import lc2k_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = LC2K_NUM_REGS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [REG_IDX_W-1:0] rd_addr_a,
    input  logic [REG_IDX_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]    rd_data_a,
    output logic [DATA_W-1:0]    rd_data_b
);
    logic [DATA_W-1:0]    regs_reg [NUM_REGS];
    logic [REG_IDX_W-1:0] rd_addr  [2];
    logic [DATA_W-1:0]    rd_data  [2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en && wr_addr != '0) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
`ifdef LC2K_DECODE_WB_BYPASS_EN
            assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 :
                                 (wr_en && wr_addr == rd_addr[gi]) ? wr_data :
                                 regs_reg[rd_addr[gi]];
`else
            assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 : regs_reg[rd_addr[gi]];
`endif
        end
    endgenerate

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];
endmodule

// File: rtl/lc2k_decode_stage.sv
// LC2K decode stage: field decode, register read, load-use stall, ID/EX register.
// Same-cycle write-back visibility is selected by LC2K_DECODE_WB_BYPASS_EN.
module lc2k_decode_stage
    import lc2k_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int NUM_REGS = LC2K_NUM_REGS
) (
    input  logic               clk,
    input  logic               rst_n,
    lc2k_decode_stage_if.slave bus
);
    typedef struct packed {
        id_ex_ctrl_t       ctrl;
        logic [DATA_W-1:0] val_a;
        logic [DATA_W-1:0] val_b;
        logic [DATA_W-1:0] offset;
        logic [PC_W-1:0]   pc_plus_one;
    } id_ex_reg_t;

    if_id_fields_t     in_f;
    id_ex_reg_t        id_ex_reg;
    id_ex_reg_t        id_ex_next;
    logic              out_valid_reg;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              lw_in_ex;
    logic              match_a;
    logic              match_b;
    logic              hz;
    logic              adv;
    logic              load_en;
    logic              unused_instr_hi;

    always_comb begin
        in_f        = '0;
        in_f.opcode = opcode_e'(bus.in_instr[OPCODE_MSB:OPCODE_LSB]);
        in_f.reg_a  = bus.in_instr[REG_A_MSB:REG_A_LSB];
        in_f.reg_b  = bus.in_instr[REG_B_MSB:REG_B_LSB];
        in_f.dest   = bus.in_instr[DEST_MSB:DEST_LSB];
        in_f.offset = bus.in_instr[OFFSET_MSB:OFFSET_LSB];
    end

    assign unused_instr_hi = ^bus.in_instr[31:OPCODE_MSB+1];

    lc2k_regfile_p #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (bus.wb_en),
        .wr_addr   (bus.wb_reg),
        .wr_data   (bus.wb_data),
        .rd_addr_a (in_f.reg_a),
        .rd_addr_b (in_f.reg_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    // A load's destination is its regB field; only sources the incoming
    // instruction really reads may trigger the stall.
    assign lw_in_ex = out_valid_reg && (id_ex_reg.ctrl.opcode == OP_LW) &&
                      (id_ex_reg.ctrl.reg_b != '0);
    assign match_a  = uses_reg_a(in_f.opcode) && (in_f.reg_a == id_ex_reg.ctrl.reg_b);
    assign match_b  = uses_reg_b(in_f.opcode) && (in_f.reg_b == id_ex_reg.ctrl.reg_b);
    assign hz       = bus.in_valid && lw_in_ex && (match_a || match_b);
    assign adv      = !out_valid_reg || bus.out_ready;
    assign load_en  = bus.in_valid && !hz;

    assign bus.in_ready = !rst_n ? 1'b0 : (bus.flush ? 1'b1 : (adv && !hz));

    always_comb begin
        id_ex_next                  = '0;
        id_ex_next.ctrl.opcode      = in_f.opcode;
        id_ex_next.ctrl.reg_a       = in_f.reg_a;
        id_ex_next.ctrl.reg_b       = in_f.reg_b;
        id_ex_next.ctrl.dest        = in_f.dest;
        id_ex_next.val_a            = rd_data_a;
        id_ex_next.val_b            = rd_data_b;
        id_ex_next.offset           = DATA_W'($signed(in_f.offset));
        id_ex_next.pc_plus_one      = bus.in_pc_plus_one;
    end

    // Flush kills both the incoming instruction and whatever sits in ID/EX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            id_ex_reg     <= '0;
        end else if (bus.flush) begin
            out_valid_reg <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= load_en;
            if (load_en) begin
                id_ex_reg <= id_ex_next;
            end
        end
    end

    assign bus.out_valid       = out_valid_reg;
    assign bus.out_opcode      = id_ex_reg.ctrl.opcode;
    assign bus.out_reg_a       = id_ex_reg.ctrl.reg_a;
    assign bus.out_reg_b       = id_ex_reg.ctrl.reg_b;
    assign bus.out_dest        = id_ex_reg.ctrl.dest;
    assign bus.out_val_a       = id_ex_reg.val_a;
    assign bus.out_val_b       = id_ex_reg.val_b;
    assign bus.out_offset      = id_ex_reg.offset;
    assign bus.out_pc_plus_one = id_ex_reg.pc_plus_one;
endmodule
